// File: rtl/ac97_cmd_sequencer_if.sv
// ac97_cmd_sequencer_if
//   Bundles the frame-engine and host signals of the AC97 command sequencer.
//   slave  : the sequencer (samples done and host request, drives the slot fields)
//   master : the environment (frame engine done pulse, host request source)
//   Signals: done, HostReq, HostReg[6:0], HostData[15:0]  -> sequencer
//            HostAck, Register[7:0], command[15:0], validate, InitDone, Busy -> environment
interface ac97_cmd_sequencer_if;
  logic        done;
  logic        HostReq;
  logic [6:0]  HostReg;
  logic [15:0] HostData;
  logic        HostAck;
  logic [7:0]  Register;
  logic [15:0] command;
  logic        validate;
  logic        InitDone;
  logic        Busy;

  modport master (
    output done, HostReq, HostReg, HostData,
    input  HostAck, Register, command, validate, InitDone, Busy
  );

  modport slave (
    input  done, HostReq, HostReg, HostData,
    output HostAck, Register, command, validate, InitDone, Busy
  );
endinterface

// File: rtl/ac97_cmd_sequencer.sv
// ac97_cmd_sequencer
//   Command-side controller for the AC97 frame engine. After reset it waits
//   POWERUP_FRAMES frames, sends the codec init table (with an idle gap after
//   the codec reset write), then forwards host register writes, one per frame.
//   Ports:
//     AC97BitClock : bit clock, all logic on rising edge
//     RstN         : asynchronous active-low reset
//     bus          : slave side of ac97_cmd_sequencer_if (done, host request,
//                    HostAck, Register/command/validate, InitDone, Busy)
module ac97_cmd_sequencer #(
  parameter int POWERUP_FRAMES   = 16,
  parameter int RESET_GAP_FRAMES = 4
) (
  input  logic                 AC97BitClock,
  input  logic                 RstN,
  ac97_cmd_sequencer_if.slave  bus
);

  localparam int CNT_MAX = (POWERUP_FRAMES > RESET_GAP_FRAMES) ? POWERUP_FRAMES : RESET_GAP_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Tick count at which POWERUP leaves, and gap count at which the gap exits.
  localparam logic [CNT_W-1:0] PU_LAST = CNT_W'(POWERUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(RESET_GAP_FRAMES);
  localparam logic [2:0]       IDX_LAST = 3'd5;

  typedef enum logic [2:0] {
    POWERUP, INIT_SEND, RESET_GAP, INIT_END, IDLE, HOST_HOLD
  } state_t;

  state_t           state;
  logic             done_q;
  logic             frame_tick;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [23:0]      rom_word;

  // {register, data} of the codec init table.
  function automatic logic [23:0] init_rom(input logic [2:0] i);
    case (i)
      3'd0:    init_rom = {8'h00, 16'h0000};  // codec reset
      3'd1:    init_rom = {8'h02, 16'h0000};  // master volume
      3'd2:    init_rom = {8'h04, 16'h0000};  // headphone
      3'd3:    init_rom = {8'h18, 16'h0808};  // PCM out
      3'd4:    init_rom = {8'h1A, 16'h0404};  // record select
      3'd5:    init_rom = {8'h1C, 16'h0000};  // record gain
      default: init_rom = 24'h0;
    endcase
  endfunction

  assign frame_tick = bus.done & ~done_q;
  assign rom_word   = init_rom(idx);

  // Slot fields only move on a frame tick (bit 128), so they are settled well
  // before the engine samples them in bits 0-51 of the next frame.
  always_ff @(posedge AC97BitClock or negedge RstN) begin
    if (!RstN) begin
      state        <= POWERUP;
      done_q       <= 1'b0;
      cnt          <= '0;
      idx          <= '0;
      bus.Register <= '0;
      bus.command  <= '0;
      bus.validate <= 1'b0;
      bus.HostAck  <= 1'b0;
      bus.InitDone <= 1'b0;
      bus.Busy     <= 1'b1;
    end else begin
      done_q      <= bus.done;
      bus.HostAck <= 1'b0;
      if (frame_tick) begin
        // Blank slot unless a state below drives an entry.
        bus.Register <= '0;
        bus.command  <= '0;
        bus.validate <= 1'b0;
        case (state)
          POWERUP: begin
            if (cnt == PU_LAST) begin
              cnt   <= '0;
              state <= INIT_SEND;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          INIT_SEND: begin
            {bus.Register, bus.command} <= rom_word;
            bus.validate <= 1'b1;
            idx          <= idx + 3'd1;
            if (idx == 3'd0)          state <= RESET_GAP;
            else if (idx == IDX_LAST) state <= INIT_END;
          end
          RESET_GAP: begin
            // The exit tick already carries entry 1 (idx was advanced past 0).
            if (cnt == GAP_END) begin
              cnt <= '0;
              {bus.Register, bus.command} <= rom_word;
              bus.validate <= 1'b1;
              idx          <= idx + 3'd1;
              state        <= INIT_SEND;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          INIT_END: begin
            bus.InitDone <= 1'b1;
            bus.Busy     <= 1'b0;
            state        <= IDLE;
          end
          IDLE, HOST_HOLD: begin
            // HOST_HOLD re-applies the idle rule, so a held request streams
            // one write per frame.
            if (bus.HostReq) begin
              bus.Register <= {1'b0, bus.HostReg};
              bus.command  <= bus.HostData;
              bus.validate <= 1'b1;
              bus.HostAck  <= 1'b1;
              bus.Busy     <= 1'b1;
              state        <= HOST_HOLD;
            end else begin
              bus.Busy <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= POWERUP;
        endcase
      end
    end
  end

endmodule
